regfile_wb_sched: RTL and testbench
===================================

# regfile_wb_sched

Write-back scheduler for the 32x32 MIPS register file. Owns the register file's single write port (`RegWrite` address, `writeData`, `regWriteC` enable). After reset it zero-fills registers 1..31 through that port. It then arbitrates between the ALU and memory write-back requesters using a valid/ready handshake. It sits between the execute/memory stages and `registers`.

## Interface
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, register data width
- `NUM_REGS`, 32, register count; the last address is `NUM_REGS-1`
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU write-back request
- `alu_addr`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `alu_ready`  out  1  ALU request accepted this cycle
- `mem_valid`  in  1  load write-back request
- `mem_addr`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load data
- `mem_ready`  out  1  load request accepted this cycle
- `rf_addr`  out  ADDR_W  to `RegWrite`
- `rf_data`  out  DATA_W  to `writeData`
- `rf_we`  out  1  to `regWriteC`
- `init_done`  out  1  high once the zero-fill is complete

## Operation
- States: `ST_INIT`, `ST_RUN`. Reset forces `ST_INIT` and loads the fill counter with 1.
- Reset values: `rf_we`=0, `rf_addr`=0, `rf_data`=0, `init_done`=0, `alu_ready`=0, `mem_ready`=0.
- `ST_INIT` behaviour:
  - Each cycle registers `rf_we`=1, `rf_addr`=counter, `rf_data`=0, then increments the counter.
  - After address `NUM_REGS-1` has been issued, moves to `ST_RUN` and sets `init_done`=1.
  - Both readies stay 0 throughout.
- `ST_RUN` behaviour:
  - Readies are combinational from the valids and the arbiter state. At most one ready is high per cycle, and only when the matching valid is high.
  - A handshake is `valid & ready` at the rising edge. On the next cycle, `rf_addr`/`rf_data` hold the captured request and `rf_we`=1.
  - If no handshake occurs, `rf_we`=0 and `rf_addr`/`rf_data` hold their previous values.
- Writes to address 0 are accepted (ready=1) but `rf_we` stays 0.
- A requester holds valid, addr and data stable until it sees ready.
- When both requesters are valid, only one is granted; the loser is granted on the following cycle. Both target the same register: the later-granted write determines the final value.
- Reset asserted mid-operation: any pending write is dropped; all outputs return to their reset values asynchronously, and the zero-fill restarts from register 1.

## Timing
- Zero-fill duration:
  - The first rising edge after reset deassertion drives `rf_addr`=1, `rf_we`=1.
  - Edge 31 drives `rf_addr`=31.
  - Edge 32 sets `rf_we`=0 and `init_done`=1.
  - The earliest possible ready is the cycle after edge 32.
- Write-back latency is 1 cycle from handshake edge to `rf_we`.
- Sustained throughput is one write per cycle. Back-to-back grants produce consecutive `rf_we` pulses with no bubble.
- `init_done` never falls except on reset.

## Configuration
- `RR_ARB_EN` defined: round-robin arbitration.
  - Under contention, the requester not granted last wins.
  - A last-grant flag resets to MEM, so the first contention goes to ALU.
  - An uncontended grant updates the flag.
- `RR_ARB_EN` undefined: fixed priority, MEM > ALU. ALU is granted only in cycles where `mem_valid`=0.

## Structure
- Shared package `regfile_pkg` holds:
  - `ADDR_W`, `DATA_W`, `NUM_REGS`
  - state enum `{ST_INIT, ST_RUN}`
  - requester IDs `REQ_ALU`=0, `REQ_MEM`=1
- One sub-module, `wb_rr_arbiter`, is natural: a 2-way grant with the last-grant flag under `RR_ARB_EN`.
- The top level keeps the FSM, fill counter and output registers.

## Test plan
- Reset low 3 cycles, then high, no requests -> `rf_we`=1 with `rf_addr` 1..31 and `rf_data`=0 on edges 1..31. `init_done`=1 from edge 32. Readies 0 throughout the fill.
- After `init_done`, `alu_valid`=1, `alu_addr`=4, `alu_data`=32'hF -> `alu_ready`=1 same cycle. Next cycle `rf_we`=1, `rf_addr`=4, `rf_data`=32'hF.
- Both valid every cycle: ALU addr 5 data 1, MEM addr 5 data 2 ->
  - With `RR_ARB_EN`: grants alternate ALU, MEM, ALU. After the first two writes, r5=2.
  - Without `RR_ARB_EN`: MEM is granted continuously while valid; ALU is never granted.
- `mem_valid`=1, `mem_addr`=0, `mem_data`=32'hDEAD -> `mem_ready`=1. `rf_we` stays 0.
- Reset pulled low at fill address 17 and released -> all outputs 0 during reset. The fill restarts at address 1, and `init_done` rises 32 edges after release.
- A grant handshake followed by reset asserted before the next edge -> `rf_we` never pulses for that write.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way write-back grant. RR_ARB_EN selects round-robin with a last-grant
// flag; otherwise fixed priority MEM > ALU.
module wb_rr_arbiter
  import regfile_pkg::*;
(
`ifdef RR_ARB_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic alu_req,
  input  logic mem_req,
  output logic alu_gnt,
  output logic mem_gnt
);

`ifdef RR_ARB_EN
  logic last;

  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (alu_req && mem_req) begin
      // Under contention the side not granted last time wins.
      alu_gnt = (last == REQ_MEM);
      mem_gnt = (last == REQ_ALU);
    end else begin
      alu_gnt = alu_req;
      mem_gnt = mem_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= REQ_MEM;
    end else if (alu_gnt || mem_gnt) begin
      last <= mem_gnt ? REQ_MEM : REQ_ALU;
    end
  end
`else
  always_comb begin
    mem_gnt = mem_req;
    alu_gnt = alu_req && !mem_req;
  end
`endif

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler owning the register file write port: zero-fills
// r1..r31 after reset, then arbitrates ALU/MEM writes (RR_ARB_EN: round-robin).
module regfile_wb_sched
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_we,
  output logic              init_done
);

  localparam logic [ADDR_W:0] FILL_END = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_t          state;
  logic [ADDR_W:0] cnt;
  logic            run;
  logic            take_alu;
  logic            take_mem;

  assign run = (state == ST_RUN);

  wb_rr_arbiter u_arb (
`ifdef RR_ARB_EN
    .clk     (clk),
    .reset   (reset),
`endif
    .alu_req (alu_valid && run),
    .mem_req (mem_valid && run),
    .alu_gnt (alu_ready),
    .mem_gnt (mem_ready)
  );

  assign take_alu = alu_valid && alu_ready;
  assign take_mem = mem_valid && mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      cnt       <= CNT_ONE;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_data   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          // Counter runs one past the last register so the edge after the
          // final fill write is the one that raises init_done.
          if (cnt == FILL_END) begin
            rf_we     <= 1'b0;
            init_done <= 1'b1;
            state     <= ST_RUN;
          end else begin
            rf_we   <= 1'b1;
            rf_addr <= cnt[ADDR_W-1:0];
            rf_data <= '0;
            cnt     <= cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (take_mem) begin
            rf_addr <= mem_addr;
            rf_data <= mem_data;
            rf_we   <= (mem_addr != '0);
          end else if (take_alu) begin
            rf_addr <= alu_addr;
            rf_data <= alu_data;
            rf_we   <= (alu_addr != '0);
          end else begin
            rf_we <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched; expected writes are queued by the
// stimulus and popped by a monitor on every rf_we pulse.
module tb_regfile_wb_sched;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              alu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_addr = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              alu_ready;
  logic              mem_valid = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              mem_ready;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              rf_we;
  logic              init_done;

  regfile_wb_sched dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .rf_we     (rf_we),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit mon_en  = 1'b0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", rf_addr, rf_data);
      end else begin
        check("wb_write", {rf_addr, rf_data}, exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic outs_zero(input string tag);
    check(tag, {rf_we, rf_addr, rf_data, init_done, alu_ready, mem_ready}, 64'd0);
  endtask

  // Called at the negedge where reset was just released.
  task automatic fill_seq();
    for (int i = 1; i < NUM_REGS; i++) push(ADDR_W'(i), '0);
    for (int i = 1; i <= NUM_REGS; i++) begin
      @(negedge clk);
      if (i < NUM_REGS) check("fill_busy", {init_done, alu_ready, mem_ready}, 64'd0);
      else              check("fill_done", {init_done, rf_we}, 64'b10);
    end
    check("fill_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Drive one request cycle starting at a negedge; readies checked 1ns later.
  task automatic req(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                     input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                     input logic [1:0] exp_rdy);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1 check("readies", {alu_ready, mem_ready}, 64'(exp_rdy));
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    outs_zero("reset_vals");
    mon_en = 1'b1;
    reset  = 1'b1;
    fill_seq();

    push(5'd4, 32'hF);
    req(1'b1, 5'd4, 32'hF, 1'b0, 5'd0, 32'h0, 2'b10);
    push(5'd6, 32'h7);
    req(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h7, 2'b01);

    for (int k = 0; k < 3; k++) begin
`ifdef RR_ARB_EN
      if (k % 2 == 0) push(5'd5, 32'd1); else push(5'd5, 32'd2);
      alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'd1;
      mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'd2;
      #1 check("rr_contend", {alu_ready, mem_ready}, (k % 2 == 0) ? 64'b10 : 64'b01);
`else
      push(5'd5, 32'd2);
      alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'd1;
      mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'd2;
      #1 check("fixed_contend", {alu_ready, mem_ready}, 64'b01);
`endif
      if (k > 0) check("b2b_we", {rf_we, rf_addr}, {58'd0, 1'b1, 5'd5});
      @(negedge clk);
    end

    push(5'd5, 32'd1);
    req(1'b1, 5'd5, 32'd1, 1'b0, 5'd0, 32'h0, 2'b10);
    req(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD, 2'b01);
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1 check("addr0_no_we", {58'd0, rf_we}, 64'd0);
    check("run_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("init_done_held", {63'd0, init_done}, 64'd1);

    mon_en = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (17) @(negedge clk);
    check("fill_at17", {rf_we, rf_addr}, {58'd0, 1'b1, 5'd17});
    reset = 1'b0;
    #1 outs_zero("midreset_async");
    @(negedge clk);
    outs_zero("midreset_held");
    mon_en = 1'b1;
    reset  = 1'b1;
    fill_seq();

    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h55;
    #1 check("pre_reset_ready", {alu_ready, mem_ready}, 64'b10);
    reset = 1'b0;
    #1 outs_zero("grant_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dropped_write", {58'd0, rf_we}, 64'd0);
    end
    alu_valid = 1'b0;
    check("end_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
